// File: rtl/stream_burst_writer.sv
// -----------------------------------------------------------------------------
// stream_burst_writer
//
// Drains the 64-bit camera stream FIFO (first-word-fall-through read side)
// into frame memory as fixed-length AXI3-style write bursts. One burst moves
// through an address phase, a data phase and a response phase. Bursts walk a
// linear frame buffer upward from a base address. The block pulses frame_done
// after each frame and keeps a sticky error flag for non-OKAY responses.
//
// Optional feature macro: STREAMWR_DBLBUF_EN
//   When defined, a second base address (frame_base2) is latched on start.
//   A bank bit then alternates frames between the two buffers, and bank_rd
//   reports the bank that holds the last completed frame.
//
// Ports
//   fclk, rst            clock; synchronous active-high reset
//   start, stop          arm the writer / halt at the next frame boundary
//   frame_base           frame buffer base (BURST_LEN*8-byte aligned)
//   frame_base2          second buffer base       (STREAMWR_DBLBUF_EN only)
//   frame_bursts         frame size in bursts; 0 behaves as 1
//   fifo_dout/valid/rd   FIFO head word, not-empty flag, pop strobe
//   burst_valid          FIFO holds at least one full burst
//   aw*                  write address channel (awlen is constant)
//   w*                   write data channel
//   bvalid/bready/bresp  write response channel
//   busy                 writer active or armed
//   frame_done           1-cycle pulse after the last response of a frame
//   err                  sticky: some response was not OKAY
//   bank_rd              bank of last completed frame (STREAMWR_DBLBUF_EN only)
// -----------------------------------------------------------------------------
module stream_burst_writer #(
   parameter int ADDR_W    = 32,
   parameter int BURST_LEN = 16,
   parameter int FBURST_W  = 16
) (
   input  logic                fclk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [ADDR_W-1:0]   frame_base,
`ifdef STREAMWR_DBLBUF_EN
   input  logic [ADDR_W-1:0]   frame_base2,
   output logic                bank_rd,
`endif
   input  logic [FBURST_W-1:0] frame_bursts,
   input  logic [63:0]         fifo_dout,
   input  logic                fifo_valid,
   output logic                fifo_rd,
   input  logic                burst_valid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [3:0]          awlen,
   output logic                awvalid,
   input  logic                awready,
   output logic [63:0]         wdata,
   output logic                wvalid,
   input  logic                wready,
   output logic                wlast,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                busy,
   output logic                frame_done,
   output logic                err
);

   localparam int                 BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * 8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  armed_q, armed_d;
   logic                  stop_pend_q, stop_pend_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [FBURST_W-1:0]   fbursts_q, fbursts_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [FBURST_W-1:0]   bcnt_q, bcnt_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  err_q, err_d;
   logic                  frame_done_q, frame_done_d;
`ifdef STREAMWR_DBLBUF_EN
   logic [ADDR_W-1:0]     base2_q, base2_d;
   logic                  bank_q, bank_d;
   logic                  bank_rd_q, bank_rd_d;
`endif

   logic w_hs;
   logic start_ok;

   // The data channel only offers a beat while the FIFO has one, and the FIFO
   // is popped exactly when that beat is accepted.
   assign wvalid   = (state_q == S_DATA) && fifo_valid;
   assign w_hs     = wvalid && wready;
   assign fifo_rd  = w_hs;
   assign start_ok = start && (state_q == S_IDLE) && !armed_q;

   always_comb begin
      // NOTE: every _d defaults to its _q value first, so no path through this block leaves a latch.
      state_d      = state_q;
      armed_d      = armed_q;
      stop_pend_d  = stop_pend_q;
      base_d       = base_q;
      fbursts_d    = fbursts_q;
      addr_d       = addr_q;
      bcnt_d       = bcnt_q;
      beat_d       = beat_q;
      err_d        = err_q;
      frame_done_d = 1'b0;
`ifdef STREAMWR_DBLBUF_EN
      base2_d      = base2_q;
      bank_d       = bank_q;
      bank_rd_d    = bank_rd_q;
`endif

      // A stop only has meaning while the writer is armed. It is held until
      // the frame's last response arrives.
      if (stop && armed_q) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // Waiting for a full burst prevents an underrun from ever splitting a burst.
            if (armed_q && burst_valid) begin
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (awready) begin
               state_d = S_DATA;
               beat_d  = '0;
            end
         end
         S_DATA: begin
            if (w_hs) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (bvalid) begin
               err_d   = err_q | (bresp != 2'b00);
               state_d = S_IDLE;
               if (bcnt_q == fbursts_q - FBURST_W'(1)) begin
                  frame_done_d = 1'b1;
                  bcnt_d       = '0;
`ifdef STREAMWR_DBLBUF_EN
                  bank_d       = ~bank_q;
                  bank_rd_d    = bank_q;
                  addr_d       = bank_q ? base_q : base2_q;
`else
                  addr_d       = base_q;
`endif
                  // A stop that arrives with the final response still ends this frame.
                  if (stop_pend_q || stop) begin
                     armed_d     = 1'b0;
                     stop_pend_d = 1'b0;
                  end
               end else begin
                  addr_d = addr_q + BURST_BYTES;
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A start is accepted only when the writer is idle and unarmed. It
      // overrides a stop in the same cycle.
      if (start_ok) begin
         armed_d     = 1'b1;
         stop_pend_d = 1'b0;
         base_d      = frame_base;
         fbursts_d   = (frame_bursts == '0) ? FBURST_W'(1) : frame_bursts;
         bcnt_d      = '0;
         err_d       = 1'b0;
`ifdef STREAMWR_DBLBUF_EN
         base2_d     = frame_base2;
         addr_d      = bank_q ? frame_base2 : frame_base;
`else
         addr_d      = frame_base;
`endif
      end
   end

   always_ff @(posedge fclk) begin
      // NOTE: the latched base and size are reset as well, even though start reloads them, so awaddr reads 0 out of reset.
      if (rst) begin
         state_q      <= S_IDLE;
         armed_q      <= 1'b0;
         stop_pend_q  <= 1'b0;
         base_q       <= '0;
         fbursts_q    <= FBURST_W'(1);
         addr_q       <= '0;
         bcnt_q       <= '0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef STREAMWR_DBLBUF_EN
         base2_q      <= '0;
         bank_q       <= 1'b0;
         bank_rd_q    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the same pre-edge values.
         state_q      <= state_d;
         armed_q      <= armed_d;
         stop_pend_q  <= stop_pend_d;
         base_q       <= base_d;
         fbursts_q    <= fbursts_d;
         addr_q       <= addr_d;
         bcnt_q       <= bcnt_d;
         beat_q       <= beat_d;
         err_q        <= err_d;
         frame_done_q <= frame_done_d;
`ifdef STREAMWR_DBLBUF_EN
         base2_q      <= base2_d;
         bank_q       <= bank_d;
         bank_rd_q    <= bank_rd_d;
`endif
      end
   end

   assign awaddr     = addr_q;
   assign awlen      = 4'(BURST_LEN - 1);
   assign awvalid    = (state_q == S_ADDR);
   assign wdata      = (state_q == S_DATA) ? fifo_dout : 64'h0;
   assign wlast      = (state_q == S_DATA) && (beat_q == LAST_BEAT);
   assign bready     = (state_q == S_RESP);
   assign busy       = (state_q != S_IDLE) || armed_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
`ifdef STREAMWR_DBLBUF_EN
   assign bank_rd    = bank_rd_q;
`endif

endmodule
